// File: rtl/mac_ctrl_tx_pkg.sv
// MAC control-frame TX shared definitions.
// Frame field offsets, frame length and FSM state encoding.
package mac_ctrl_tx_pkg;

  localparam int MCF_OFF_DST    = 0;
  localparam int MCF_OFF_SRC    = 6;
  localparam int MCF_OFF_TYPE   = 12;
  localparam int MCF_OFF_OPCODE = 14;
  localparam int MCF_OFF_PARAMS = 16;
  localparam int MCF_FRAME_LEN  = 60;
  localparam int MCF_PARAMS_MAX = MCF_FRAME_LEN - MCF_OFF_PARAMS;

  localparam logic [5:0] MCF_LAST_BYTE = 6'(MCF_FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_MCF
  } state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Registered two-entry AXI-stream skid buffer, one cycle latency.
// Ports: s_* upstream (data/valid/ready), m_* downstream, clk, rst_n.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             out_v;
  logic             skid_v;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] skid_d;
  logic             out_free;

  // ready depends only on state, never on m_ready
  assign s_ready  = !skid_v;
  assign m_valid  = out_v;
  assign m_data   = out_d;
  assign out_free = !out_v || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (m_ready) skid_v <= 1'b0;
    end else if (s_valid) begin
      if (out_free) out_v <= 1'b1;
      else          skid_v <= 1'b1;
    end else if (m_ready) begin
      out_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_v) begin
      if (m_ready) out_d <= skid_d;
    end else if (s_valid) begin
      if (out_free) out_d  <= s_data;
      else          skid_d <= s_data;
    end
  end

endmodule

// File: rtl/mac_ctrl_tx.sv
// MAC TX arbiter: passes client frames, injects 60-byte control frames.
// Ports: s_axis client in, m_axis to MAC, mcf_* request, busy/stat out.
module mac_ctrl_tx
  import mac_ctrl_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ID_WIDTH        = 8,
  parameter int DEST_WIDTH      = 8,
  parameter int USER_WIDTH      = 1,
  parameter int MCF_PARAMS_SIZE = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  mcf_valid,
  output logic                  mcf_ready,
  input  logic [47:0]           mcf_eth_dst,
  input  logic [47:0]           mcf_eth_src,
  input  logic [15:0]           mcf_eth_type,
  input  logic [15:0]           mcf_opcode,
  input  logic [((MCF_PARAMS_SIZE > 0) ? MCF_PARAMS_SIZE*8 : 8)-1:0]
                                mcf_params,
  input  logic [ID_WIDTH-1:0]   mcf_id,
  input  logic [DEST_WIDTH-1:0] mcf_dest,
  input  logic [USER_WIDTH-1:0] mcf_user,
  output logic                  tx_mcf_busy,
  output logic                  stat_tx_mcf
);

  localparam int PB = (MCF_PARAMS_SIZE > 0) ? MCF_PARAMS_SIZE*8 : 8;
  localparam int NP = (MCF_PARAMS_SIZE > MCF_PARAMS_MAX) ? MCF_PARAMS_MAX :
                      (MCF_PARAMS_SIZE < 0) ? 0 : MCF_PARAMS_SIZE;
  localparam int PW = DATA_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  if (DATA_WIDTH != 8) begin : g_dw_chk
    $error("mac_ctrl_tx: DATA_WIDTH must be 8");
  end
  if (MCF_PARAMS_SIZE < 0 || MCF_PARAMS_SIZE > MCF_PARAMS_MAX) begin : g_ps_chk
    $error("mac_ctrl_tx: MCF_PARAMS_SIZE must be 0..44");
  end

  state_t state_q;
  state_t state_d;

  logic                  en_q;
  logic [5:0]            cnt_q;
  logic                  stat_q;

  logic [47:0]           dst_q;
  logic [47:0]           src_q;
  logic [15:0]           type_q;
  logic [15:0]           op_q;
  logic [PB-1:0]         params_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [USER_WIDTH-1:0] user_q;

  logic                  pass_en;
  logic                  s_hs;
  logic                  mcf_take;
  logic                  mcf_last;
  logic                  buf_in_valid;
  logic                  buf_in_ready;
  logic [PW-1:0]         buf_in;
  logic [PW-1:0]         buf_out;
  logic [7:0]            fb [MCF_FRAME_LEN];
  logic [DATA_WIDTH-1:0] mcf_data;

  assign s_hs     = s_axis_tvalid && s_axis_tready;
  assign mcf_take = (state_q == ST_MCF) && buf_in_ready;
  assign mcf_last = (cnt_q == MCF_LAST_BYTE);

  // en_q holds ready low until the first clock after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      stat_q  <= mcf_take && mcf_last;
      if (mcf_ready)
        cnt_q <= '0;
      else if (mcf_take)
        cnt_q <= mcf_last ? '0 : cnt_q + 6'd1;
    end
  end

  // single-beat frames are consumed in IDLE without visiting DATA
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mcf_ready)
          state_d = ST_MCF;
        else if (s_hs && !s_axis_tlast)
          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (s_hs && s_axis_tlast)
          state_d = ST_IDLE;
      end
      ST_MCF: begin
        if (mcf_take && mcf_last)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pass_en      = 1'b0;
    mcf_ready    = 1'b0;
    tx_mcf_busy  = 1'b0;
    buf_in_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mcf_ready   = en_q && mcf_valid;
        tx_mcf_busy = en_q && mcf_valid;
        pass_en     = en_q && !mcf_valid;
      end
      ST_DATA: pass_en = 1'b1;
      ST_MCF: begin
        tx_mcf_busy  = 1'b1;
        buf_in_valid = 1'b1;
      end
      default: ;
    endcase
    if (pass_en)
      buf_in_valid = s_axis_tvalid;
    s_axis_tready = pass_en && buf_in_ready;
  end

  // bad-frame bit is cleared at capture time
  always_ff @(posedge clk) begin
    if (mcf_ready) begin
      dst_q    <= mcf_eth_dst;
      src_q    <= mcf_eth_src;
      type_q   <= mcf_eth_type;
      op_q     <= mcf_opcode;
      params_q <= mcf_params;
      id_q     <= mcf_id;
      dest_q   <= mcf_dest;
      user_q   <= mcf_user & ~USER_WIDTH'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < MCF_FRAME_LEN; i++)
      fb[i] = '0;
    for (int i = 0; i < 6; i++) begin
      fb[MCF_OFF_DST+i] = dst_q[8*(5-i) +: 8];
      fb[MCF_OFF_SRC+i] = src_q[8*(5-i) +: 8];
    end
    fb[MCF_OFF_TYPE]     = type_q[15:8];
    fb[MCF_OFF_TYPE+1]   = type_q[7:0];
    fb[MCF_OFF_OPCODE]   = op_q[15:8];
    fb[MCF_OFF_OPCODE+1] = op_q[7:0];
    for (int k = 0; k < NP; k++)
      fb[MCF_OFF_PARAMS+k] = params_q[8*k +: 8];
  end

  assign mcf_data = DATA_WIDTH'(fb[cnt_q]);

  assign buf_in = (state_q == ST_MCF) ?
    {mcf_data, mcf_last, id_q, dest_q, user_q} :
    {s_axis_tdata, s_axis_tlast, s_axis_tid,
     s_axis_tdest, s_axis_tuser};

  axis_skid_buf #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (buf_in),
    .s_valid (buf_in_valid),
    .s_ready (buf_in_ready),
    .m_data  (buf_out),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tid,
          m_axis_tdest, m_axis_tuser} = buf_out;

  assign stat_tx_mcf = stat_q;

endmodule

// File: tb/tb_mac_ctrl_tx.sv
// Directed bench for mac_ctrl_tx.
// Second instance covers the 44-byte parameter block.
module tb_mac_ctrl_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [7:0]   s_tdata;
  logic         s_tvalid, s_tready, s_tlast;
  logic [7:0]   s_tid, s_tdest;
  logic [0:0]   s_tuser;
  logic [7:0]   m_tdata;
  logic         m_tvalid, m_tready, m_tlast;
  logic [7:0]   m_tid, m_tdest;
  logic [0:0]   m_tuser;
  logic         mcf_valid, mcf_ready;
  logic [47:0]  dst, src;
  logic [15:0]  ety, op;
  logic [143:0] params;
  logic [351:0] params44;
  logic [7:0]   mid, mdest;
  logic [0:0]   muser;
  logic         busy, stat;

  logic         s44_tready, m44_tvalid, m44_tlast;
  logic [7:0]   m44_tdata, m44_tid, m44_tdest;
  logic [0:0]   m44_tuser;
  logic         mcf44_ready, busy44, stat44;

  mac_ctrl_tx dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
    .m_axis_tuser(m_tuser),
    .mcf_valid(mcf_valid), .mcf_ready(mcf_ready),
    .mcf_eth_dst(dst), .mcf_eth_src(src),
    .mcf_eth_type(ety), .mcf_opcode(op),
    .mcf_params(params), .mcf_id(mid),
    .mcf_dest(mdest), .mcf_user(muser),
    .tx_mcf_busy(busy), .stat_tx_mcf(stat)
  );

  mac_ctrl_tx #(.MCF_PARAMS_SIZE(44)) dut44 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s44_tready), .s_axis_tlast(s_tlast),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m44_tdata), .m_axis_tvalid(m44_tvalid),
    .m_axis_tready(1'b1), .m_axis_tlast(m44_tlast),
    .m_axis_tid(m44_tid), .m_axis_tdest(m44_tdest),
    .m_axis_tuser(m44_tuser),
    .mcf_valid(mcf_valid), .mcf_ready(mcf44_ready),
    .mcf_eth_dst(dst), .mcf_eth_src(src),
    .mcf_eth_type(ety), .mcf_opcode(op),
    .mcf_params(params44), .mcf_id(mid),
    .mcf_dest(mdest), .mcf_user(muser),
    .tx_mcf_busy(busy44), .stat_tx_mcf(stat44)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [0:0] u;
    logic [7:0] id;
    logic [7:0] de;
    int         c;
  } beat_t;

  beat_t      q[$];
  logic [8:0] q44[$];

  int tests = 0;
  int fails = 0;
  int ncyc = 0;
  int stat_cnt = 0;
  int rdy_pulses = 0;
  int busy_bad = 0;
  int viol = 0;
  int bp = 0;
  logic s_hs, mcf_hs;

  logic [7:0] lfc [18] = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01,
                           8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
                           8'h88, 8'h08, 8'h00, 8'h01, 8'hFF, 8'hFF};

  always @(negedge clk) begin
    ncyc++;
    if (rst_n && m_tvalid && m_tready)
      q.push_back('{m_tdata, m_tlast, m_tuser, m_tid, m_tdest, ncyc});
    if (rst_n && m44_tvalid)
      q44.push_back({m44_tlast, m44_tdata});
    if (rst_n && stat)
      stat_cnt++;
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_hs   = s_tvalid && s_tready;
    mcf_hs = mcf_valid && mcf_ready;
    if (busy && s_tready) viol++;
    if (mcf_ready) begin
      rdy_pulses++;
      if (!busy) busy_bad++;
    end
    @(posedge clk);
    #1;
    if (mcf_hs) mcf_valid = 1'b0;
    if (bp != 0) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(int n, logic [7:0] base, logic u, int mcf_at);
    for (int i = 0; i < n; i++) begin
      int k;
      if (i == mcf_at) mcf_valid = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = base + 8'(i);
      s_tlast  = (i == n - 1);
      s_tuser  = u;
      k = 0;
      do begin
        step();
        k++;
      end while (!s_hs && k < 400);
      check("send_hs", s_hs, 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(int n);
    int k;
    k = 0;
    while (q.size() < n && k < 3000) begin
      step();
      k++;
    end
    check("beats_reached", q.size() >= n, 1);
  endtask

  function automatic logic [7:0] mcf_exp(int i);
    if (i < 6)       return dst[8*(5-i) +: 8];
    else if (i < 12) return src[8*(11-i) +: 8];
    else if (i == 12) return ety[15:8];
    else if (i == 13) return ety[7:0];
    else if (i == 14) return op[15:8];
    else if (i == 15) return op[7:0];
    else if (i < 34) return params[8*(i-16) +: 8];
    else             return 8'h00;
  endfunction

  initial begin
    int nlast;
    logic [7:0] e;
    rst_n = 1'b0;
    s_tdata = '0; s_tvalid = 1'b1; s_tlast = 1'b0;
    s_tid = '0; s_tdest = '0; s_tuser = '0;
    m_tready = 1'b1;
    mcf_valid = 1'b1;
    dst = 48'h0180C2000001;
    src = 48'h02AABBCCDDEE;
    ety = 16'h8808;
    op = 16'h0001;
    params = 144'hFFFF;
    for (int k = 0; k < 44; k++) params44[8*k +: 8] = 8'h40 + 8'(k);
    mid = 8'h3C; mdest = 8'h5A; muser = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_mcf_ready", mcf_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_stat", stat, 0);
    s_tvalid = 1'b0;
    mcf_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();

    // LFC frame with free-running sink
    mcf_valid = 1'b1;
    wait_beats(60);
    repeat (3) step();
    check("lfc_count", q.size(), 60);
    for (int i = 0; i < 60; i++) begin
      e = (i < 18) ? lfc[i] : 8'h00;
      check("lfc_beat", {q[i].l, q[i].u, q[i].d}, {(i == 59), 1'b0, e});
    end
    check("lfc_side", {q[0].id, q[0].de}, 16'h3C5A);
    check("lfc_rate", q[59].c - q[0].c, 59);
    check("lfc_stat", stat_cnt, 1);
    check("lfc_rdy", rdy_pulses, 1);
    check("lfc_busy_end", busy, 0);
    check("p44_count", q44.size(), 60);
    for (int i = 16; i < 60; i++)
      check("p44_beat", q44[i], {(i == 59), 8'h40 + 8'(i - 16)});
    q.delete();
    q44.delete();

    // request raised during a 100-byte pass-through frame
    op = 16'h0101;
    params = 144'h1234;
    s_tid = 8'h05;
    s_tdest = 8'h06;
    send_frame(100, 8'h00, 1'b0, 3);
    wait_beats(160);
    repeat (3) step();
    check("pt_count", q.size(), 160);
    for (int i = 0; i < 100; i++)
      check("pt_beat", {q[i].l, q[i].u, q[i].d, q[i].id, q[i].de},
            {(i == 99), 1'b0, 8'(i), 8'h05, 8'h06});
    for (int i = 0; i < 60; i++)
      check("pt_mcf", {q[100+i].l, q[100+i].d}, {(i == 59), mcf_exp(i)});
    check("pt_gap", (q[100].c - q[99].c) <= 2, 1);
    check("pt_mcf_side", {q[100].id, q[100].de}, 16'h3C5A);
    check("pt_stat", stat_cnt, 2);
    q.delete();

    // simultaneous request and data
    viol = 0;
    mcf_valid = 1'b1;
    send_frame(4, 8'hA0, 1'b0, -1);
    wait_beats(64);
    repeat (3) step();
    check("sim_count", q.size(), 64);
    check("sim_tready_in_mcf", viol, 0);
    for (int i = 0; i < 60; i++)
      check("sim_mcf", {q[i].l, q[i].d}, {(i == 59), mcf_exp(i)});
    for (int i = 0; i < 4; i++)
      check("sim_data", {q[60+i].l, q[60+i].d}, {(i == 3), 8'hA0 + 8'(i)});
    check("sim_stat", stat_cnt, 3);
    q.delete();

    // random backpressure, bad-frame flag on first frame
    bp = 1;
    send_frame(30, 8'h10, 1'b1, -1);
    mcf_valid = 1'b1;
    send_frame(10, 8'hC0, 1'b0, -1);
    wait_beats(100);
    bp = 0;
    m_tready = 1'b1;
    repeat (5) step();
    check("bp_count", q.size(), 100);
    for (int i = 0; i < 30; i++)
      check("bp_d1", {q[i].l, q[i].u, q[i].d},
            {(i == 29), 1'b1, 8'h10 + 8'(i)});
    for (int i = 0; i < 60; i++)
      check("bp_mcf", {q[30+i].l, q[30+i].u, q[30+i].d},
            {(i == 59), 1'b0, mcf_exp(i)});
    for (int i = 0; i < 10; i++)
      check("bp_d2", {q[90+i].l, q[90+i].u, q[90+i].d},
            {(i == 9), 1'b0, 8'hC0 + 8'(i)});
    check("bp_stat", stat_cnt, 4);
    q.delete();

    // reset in the middle of a control frame
    mcf_valid = 1'b1;
    wait_beats(30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_mcf_ready", mcf_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stat", stat, 0);
    repeat (2) step();
    nlast = 0;
    foreach (q[i]) if (q[i].l) nlast++;
    check("mid_rst_no_tlast", nlast, 0);
    check("mid_rst_partial", q.size() < 60, 1);
    rst_n = 1'b1;
    q.delete();
    step();
    s_tid = 8'h09;
    send_frame(5, 8'h70, 1'b0, -1);
    wait_beats(5);
    repeat (5) step();
    check("post_rst_count", q.size(), 5);
    for (int i = 0; i < 5; i++)
      check("post_rst_beat", {q[i].l, q[i].d, q[i].id},
            {(i == 4), 8'h70 + 8'(i), 8'h09});
    check("post_rst_stat", stat_cnt, 4);
    check("busy_at_ready", busy_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_ctrl_tx.md
MAC_CTRL_TX -- requirements
Module: mac_ctrl_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8; stream width; only 8 supported, other values trigger $error.
REQ-002 SHALL have parameter ID_WIDTH, default 8; tid width.
REQ-003 SHALL have parameter DEST_WIDTH, default 8; tdest width.
REQ-004 SHALL have parameter USER_WIDTH, default 1; tuser width, bit 0 is the bad-frame flag.
REQ-005 SHALL have parameter MCF_PARAMS_SIZE, default 18; parameter bytes, range 0..44, $error outside.
REQ-006 SHALL have clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have s_axis_tdata/tvalid/tready/tlast/tid/tdest/tuser  in/in/out/in/in/in/in  DATA_WIDTH/1/1/1/ID/DEST/USER  client data stream.
REQ-009 SHALL have m_axis_tdata/tvalid/tready/tlast/tid/tdest/tuser  out/out/in/out/out/out/out  same widths  stream to MAC TX.
REQ-010 SHALL have mcf_valid, mcf_ready  in, out  1, 1  control-frame request handshake.
REQ-011 SHALL have mcf_eth_dst, mcf_eth_src  in  48 each  MAC addresses, MSB byte sent first.
REQ-012 SHALL have mcf_eth_type, mcf_opcode  in  16 each  sent MSB byte first.
REQ-013 SHALL have mcf_params  in  MCF_PARAMS_SIZE*8  byte k at [k*8+:8], sent byte 0 first.
REQ-014 SHALL have mcf_id, mcf_dest, mcf_user  in  ID/DEST/USER widths  sideband for generated frame.
REQ-015 SHALL have tx_mcf_busy  out  1  high while generated frame in progress.
REQ-016 SHALL have stat_tx_mcf  out  1  one-cycle pulse per completed generated frame.

Function
REQ-017 SHALL run FSM states IDLE, DATA (pass-through frame), MCF (generate frame).
REQ-018 IDLE: mcf_valid high SHALL go to MCF, giving it priority over a simultaneously valid s_axis beat; otherwise a valid s_axis beat SHALL go to DATA.
REQ-019 DATA: s_axis SHALL be forwarded beat for beat unmodified; FSM SHALL return to IDLE after the accepted beat with tlast; mcf_valid SHALL NOT preempt a frame in progress.
REQ-020 MCF accept: mcf_ready SHALL pulse for exactly one cycle when all mcf_* fields are captured into registers on entry to MCF; inputs may change afterwards.
REQ-021 MCF frame SHALL be exactly 60 bytes: dst(6), src(6), type(2), opcode(2), params(MCF_PARAMS_SIZE), then zero padding to byte 59. FCS is not generated.
REQ-022 MCF byte counter SHALL be 6 bits, advance only on an output handshake, and assert tlast on byte 59; FSM SHALL return to IDLE with stat_tx_mcf pulsed the following cycle.
REQ-023 Generated beats SHALL carry the captured mcf_id/mcf_dest, with tuser = captured mcf_user and bit 0 forced to 0.
REQ-024 s_axis_tready SHALL be 0 in MCF and while in IDLE with mcf_valid high.
REQ-025 Output SHALL use a registered two-entry skid buffer: one cycle latency, full throughput with m_axis_tready held high, no beat lost or duplicated under arbitrary backpressure.
REQ-026 A frame with s_axis tuser[0]=1 SHALL pass through unchanged; the bad-frame flag SHALL NOT alter arbitration.
REQ-027 tx_mcf_busy SHALL be high from the mcf_ready cycle through the cycle byte 59 is accepted.

Reset
REQ-028 rst_n low SHALL asynchronously force: FSM IDLE, counter 0, m_axis_tvalid 0, skid buffer empty, s_axis_tready 0, mcf_ready 0, tx_mcf_busy 0, stat_tx_mcf 0.
REQ-029 Reset mid-frame SHALL abandon the frame without emitting tlast; the first post-reset output beat SHALL start a new frame.
REQ-030 Data registers (captured fields, output data) need not reset.

Structure
REQ-031 A shared package SHALL hold the MCF field offsets (dst 0, src 6, type 12, opcode 14, params 16), the frame length of 60, and the FSM state enumeration.
REQ-032 The skid buffer SHALL be a sub-module, axis_skid_buf, shared with other stream blocks.

Verification
REQ-033 LFC: dst 01:80:C2:00:00:01, type 0x8808, opcode 0x0001, params[0..1]=0xFFFF, m_axis_tready=1 -> 60 beats 01 80 C2 00 00 01 ... 88 08 00 01 FF FF then 42 zero bytes; tlast on beat 60; one stat_tx_mcf pulse.
REQ-034 Request during pass-through: mcf_valid raised at beat 3 of a 100-byte data frame -> data frame completes intact, then the MCF frame starts with no gap beyond one cycle.
REQ-035 Simultaneous: mcf_valid and s_axis_tvalid both asserted in IDLE -> MCF frame emitted first, s_axis_tready held 0 for its duration.
REQ-036 Backpressure: random 50% m_axis_tready -> output byte sequences match the reference model exactly, with no drops or duplicates.
REQ-037 Reset at MCF byte 30 -> all outputs at reset values within the same cycle; a following data frame passes through correctly.
REQ-038 MCF_PARAMS_SIZE=44 -> bytes 16..59 are params, with no padding.
